// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between IF and the
// byte-serial memory controller; misses become 4-byte reads, I/O space bypasses.
module icache #(
  parameter int NUM_LINES = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_rdy,
  output logic [31:0] if_ins,
  output logic [1:0]  memctl_op,
  output logic [1:0]  memctl_len,
  output logic [31:0] memctl_addr,
  input  logic        memctl_rdy,
  input  logic [31:0] memctl_out
);
  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    MISS = 2'd2
  } state_e;

  state_e               state_q;
  logic [31:2]          req_addr_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];
  logic                 if_rdy_q;
  logic [31:0]          if_ins_q;
  logic [1:0]           op_q;
  logic [1:0]           len_q;
  logic [31:0]          maddr_q;

  logic [INDEX_BITS-1:0] idx_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic                  cacheable_s;
  logic                  hit_s;
  logic                  fill_s;
  logic                  unused_s;

  assign idx_s       = req_addr_q[INDEX_BITS+1:2];
  assign tag_s       = req_addr_q[31:INDEX_BITS+2];
  assign cacheable_s = (req_addr_q[17:16] != 2'b11);
  assign hit_s       = valid_q[idx_s] && (tag_q[idx_s] == tag_s) && cacheable_s;
  // A fill lands even when flush arrives on the same edge: the returned word is still correct.
  assign fill_s      = !rst_in && rdy_in && (state_q == MISS) && memctl_rdy && cacheable_s;
  assign unused_s    = ^if_addr[1:0];

  // Lookup/refill FSM with registered IF and memory-controller outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      req_addr_q <= 30'h0;
      valid_q    <= {NUM_LINES{1'b0}};
      if_rdy_q   <= 1'b0;
      if_ins_q   <= 32'h0;
      op_q       <= 2'b00;
      len_q      <= 2'b00;
      maddr_q    <= 32'h0;
    end else if (rdy_in) begin
      if_rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_req && !flush) begin
            req_addr_q <= if_addr[31:2];
            state_q    <= CMP;
          end
        end
        CMP: begin
          if (flush) begin
            state_q <= IDLE;
          end else if (hit_s) begin
            if_rdy_q <= 1'b1;
            if_ins_q <= data_q[idx_s];
            state_q  <= IDLE;
          end else begin
            op_q    <= 2'b01;
            len_q   <= 2'b11;
            maddr_q <= {req_addr_q, 2'b00};
            state_q <= MISS;
          end
        end
        MISS: begin
          if (memctl_rdy) begin
            if (cacheable_s) begin
              valid_q[idx_s] <= 1'b1;
            end
            if (!flush) begin
              if_rdy_q <= 1'b1;
              if_ins_q <= memctl_out;
            end
            op_q    <= 2'b00;
            len_q   <= 2'b00;
            state_q <= IDLE;
          end else if (flush) begin
            op_q    <= 2'b00;
            len_q   <= 2'b00;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid_q alone decides whether a line is usable.
  always_ff @(posedge clk_in) begin
    if (fill_s) begin
      tag_q[idx_s]  <= tag_s;
      data_q[idx_s] <= memctl_out;
    end
  end

  assign if_rdy      = if_rdy_q;
  assign if_ins      = if_ins_q;
  assign memctl_op   = op_q;
  assign memctl_len  = len_q;
  assign memctl_addr = maddr_q;

endmodule
